// File: rtl/tx_prbs_qpsk_source.sv
// Transmit-side dual PRBS9 (x^9+x^5+1) I/Q bit source with optional periodic
// error injection and saturating injected-error counters.
module tx_prbs_qpsk_source #(
  parameter logic [8:0]  PRBS_SEED_I = 9'h1AA,
  parameter logic [8:0]  PRBS_SEED_Q = 9'h1FE,
  parameter int unsigned ERR_PERIOD  = 1024,
  parameter int unsigned ERR_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_en_tx,
  input  logic                 i_en_rate1,
  input  logic                 i_err_inj_en,
  input  logic [1:0]           i_err_sel,
  output logic                 o_tx_bit_I,
  output logic                 o_tx_bit_Q,
  output logic                 o_tx_valid,
  output logic                 o_inj_flag,
  output logic [ERR_CNT_W-1:0] o_err_cnt_I,
  output logic [ERR_CNT_W-1:0] o_err_cnt_Q
);

  localparam logic [15:0] WIN_LAST = 16'(ERR_PERIOD - 1);

  logic [8:0]           lfsr_i_q, lfsr_i_d, lfsr_q_q, lfsr_q_d;
  logic [15:0]          win_q, win_d;
  logic                 bit_i_q, bit_i_d, bit_q_q, bit_q_d;
  logic                 valid_q, valid_d, flag_q, flag_d;
  logic [ERR_CNT_W-1:0] cnt_i_q, cnt_i_d, cnt_q_q, cnt_q_d;
  logic                 adv, inj, inj_i, inj_q;

  // An all-zero state can only come from an upset; reload all-ones to escape it.
  function automatic logic [8:0] lfsr_next(input logic [8:0] r);
    return (r == '0) ? 9'h1FF : {r[7:0], r[8] ^ r[4]};
  endfunction

  always_comb begin
    adv      = i_en_tx & i_en_rate1;
    inj      = adv & i_err_inj_en & (win_q == WIN_LAST);
    inj_i    = inj & i_err_sel[0];
    inj_q    = inj & i_err_sel[1];
    lfsr_i_d = lfsr_i_q;
    lfsr_q_d = lfsr_q_q;
    win_d    = win_q;
    bit_i_d  = bit_i_q;
    bit_q_d  = bit_q_q;
    flag_d   = flag_q;
    cnt_i_d  = cnt_i_q;
    cnt_q_d  = cnt_q_q;
    valid_d  = adv;

    if (!i_err_inj_en) begin
      win_d = '0;
    end else if (adv) begin
      win_d = inj ? '0 : win_q + 16'd1;
    end

    if (adv) begin
      lfsr_i_d = lfsr_next(lfsr_i_q);
      lfsr_q_d = lfsr_next(lfsr_q_q);
      bit_i_d  = lfsr_i_q[8] ^ inj_i;
      bit_q_d  = lfsr_q_q[8] ^ inj_q;
      flag_d   = inj_i | inj_q;
      if (inj_i && cnt_i_q != '1) cnt_i_d = cnt_i_q + ERR_CNT_W'(1);
      if (inj_q && cnt_q_q != '1) cnt_q_d = cnt_q_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      lfsr_i_q <= PRBS_SEED_I;
      lfsr_q_q <= PRBS_SEED_Q;
      win_q    <= '0;
      bit_i_q  <= 1'b0;
      bit_q_q  <= 1'b0;
      valid_q  <= 1'b0;
      flag_q   <= 1'b0;
      cnt_i_q  <= '0;
      cnt_q_q  <= '0;
    end else begin
      lfsr_i_q <= lfsr_i_d;
      lfsr_q_q <= lfsr_q_d;
      win_q    <= win_d;
      bit_i_q  <= bit_i_d;
      bit_q_q  <= bit_q_d;
      valid_q  <= valid_d;
      flag_q   <= flag_d;
      cnt_i_q  <= cnt_i_d;
      cnt_q_q  <= cnt_q_d;
    end
  end

  assign o_tx_bit_I  = bit_i_q;
  assign o_tx_bit_Q  = bit_q_q;
  assign o_tx_valid  = valid_q;
  assign o_inj_flag  = flag_q;
  assign o_err_cnt_I = cnt_i_q;
  assign o_err_cnt_Q = cnt_q_q;

endmodule

// File: tb/tb_tx_prbs_qpsk_source.sv
// Bench for tx_prbs_qpsk_source: three parameterisations share one stimulus
// stream and are checked each cycle against a sequence/arithmetic model.
module tb_tx_prbs_qpsk_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset = 1'b0;
  logic       i_en_tx = 1'b0, i_en_rate1 = 1'b0, i_err_inj_en = 1'b0;
  logic [1:0] i_err_sel = 2'b00;

  logic        bI[3], bQ[3], vld[3], flg[3];
  logic [31:0] cIa, cQa, cIb, cQb;
  logic [2:0]  cIc, cQc;
  logic [31:0] cI[3], cQ[3];

  always_comb begin
    cI[0] = cIa; cQ[0] = cQa;
    cI[1] = cIb; cQ[1] = cQb;
    cI[2] = 32'(cIc); cQ[2] = 32'(cQc);
  end

  tx_prbs_qpsk_source dut_a (
    .clk(clk), .i_reset(i_reset), .i_en_tx(i_en_tx), .i_en_rate1(i_en_rate1),
    .i_err_inj_en(i_err_inj_en), .i_err_sel(i_err_sel),
    .o_tx_bit_I(bI[0]), .o_tx_bit_Q(bQ[0]), .o_tx_valid(vld[0]), .o_inj_flag(flg[0]),
    .o_err_cnt_I(cIa), .o_err_cnt_Q(cQa));

  tx_prbs_qpsk_source #(.ERR_PERIOD(8)) dut_b (
    .clk(clk), .i_reset(i_reset), .i_en_tx(i_en_tx), .i_en_rate1(i_en_rate1),
    .i_err_inj_en(i_err_inj_en), .i_err_sel(i_err_sel),
    .o_tx_bit_I(bI[1]), .o_tx_bit_Q(bQ[1]), .o_tx_valid(vld[1]), .o_inj_flag(flg[1]),
    .o_err_cnt_I(cIb), .o_err_cnt_Q(cQb));

  tx_prbs_qpsk_source #(.ERR_PERIOD(2), .ERR_CNT_W(3)) dut_c (
    .clk(clk), .i_reset(i_reset), .i_en_tx(i_en_tx), .i_en_rate1(i_en_rate1),
    .i_err_inj_en(i_err_inj_en), .i_err_sel(i_err_sel),
    .o_tx_bit_I(bI[2]), .o_tx_bit_Q(bQ[2]), .o_tx_valid(vld[2]), .o_inj_flag(flg[2]),
    .o_err_cnt_I(cIc), .o_err_cnt_Q(cQc));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: PRBS9 bit stream from s[n+9] = s[n] ^ s[n+4], seed MSB first.
  bit seq_i[511], seq_q[511];
  logic [8:0] seed_i = 9'h1AA, seed_q = 9'h1FE;

  initial begin
    for (int n = 0; n < 9; n++) begin
      seq_i[n] = seed_i[8-n];
      seq_q[n] = seed_q[8-n];
    end
    for (int n = 0; n < 502; n++) begin
      seq_i[n+9] = seq_i[n] ^ seq_i[n+4];
      seq_q[n+9] = seq_q[n] ^ seq_q[n+4];
    end
  end

  int     per[3] = '{1024, 8, 2};
  longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
  int     k[3], win[3];
  longint mcI[3], mcQ[3];
  bit     ebI[3], ebQ[3], ev[3], ef[3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!i_reset) begin
        k[d] = 0; win[d] = 0; mcI[d] = 0; mcQ[d] = 0;
        ebI[d] = 0; ebQ[d] = 0; ev[d] = 0; ef[d] = 0;
      end else begin
        bit adv, inj;
        adv = i_en_tx && i_en_rate1;
        inj = 0;
        if (!i_err_inj_en) win[d] = 0;
        else if (adv) begin
          win[d]++;
          if (win[d] == per[d]) begin inj = 1; win[d] = 0; end
        end
        ev[d] = adv;
        if (adv) begin
          ebI[d] = seq_i[k[d]] ^ (inj & i_err_sel[0]);
          ebQ[d] = seq_q[k[d]] ^ (inj & i_err_sel[1]);
          ef[d]  = inj && (i_err_sel != 2'b00);
          if (inj && i_err_sel[0] && mcI[d] < cmax[d]) mcI[d]++;
          if (inj && i_err_sel[1] && mcQ[d] < cmax[d]) mcQ[d]++;
          k[d] = (k[d] + 1) % 511;
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("bitI[%0d]", d), longint'(bI[d]), longint'(ebI[d]));
      chk($sformatf("bitQ[%0d]", d), longint'(bQ[d]), longint'(ebQ[d]));
      chk($sformatf("valid[%0d]", d), longint'(vld[d]), longint'(ev[d]));
      chk($sformatf("flag[%0d]", d), longint'(flg[d]), longint'(ef[d]));
      chk($sformatf("cntI[%0d]", d), longint'(cI[d]), mcI[d]);
      chk($sformatf("cntQ[%0d]", d), longint'(cQ[d]), mcQ[d]);
    end
  end

  task automatic tick(input bit tx, input bit rate, input bit ien, input logic [1:0] sel);
    @(negedge clk);
    i_en_tx = tx; i_en_rate1 = rate; i_err_inj_en = ien; i_err_sel = sel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b0;
    i_en_tx = 0; i_en_rate1 = 0; i_err_inj_en = 0; i_err_sel = 2'b00;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
  endtask

  // Literal pin of the first nine symbols against both seeds.
  task automatic check_seed();
    for (int i = 0; i < 9; i++) begin
      tick(1, 1, 0, 2'b00);
      @(posedge clk); #2;
      chk($sformatf("seedI[%0d]", i), longint'(bI[0]), longint'(seed_i[8-i]));
      chk($sformatf("seedQ[%0d]", i), longint'(bQ[0]), longint'(seed_q[8-i]));
    end
  endtask

  initial begin
    int nflag;
    do_reset();
    check_seed();
    // Two full periods plus margin: model wraps at 511.
    repeat (1100) tick(1, 1, 0, 2'b00);

    // Strobe 1-of-4, transmitter off for 10 strobes mid-way.
    for (int c = 0; c < 240; c++)
      tick(!(c >= 80 && c < 120), (c % 4) == 0, 0, 2'b00);

    // Injection on I only.
    do_reset();
    nflag = 0;
    for (int a = 1; a <= 64; a++) begin
      tick(1, 1, 1, 2'b01);
      @(posedge clk); #2;
      if (flg[1]) nflag++;
      if (a == 8) begin
        chk("b_bit8_inverted", longint'(bI[1]), 0);
        chk("a_bit8_clean", longint'(bI[0]), 1);
      end
    end
    tick(0, 0, 1, 2'b01);
    @(posedge clk); #2;
    chk("b_flag_count", nflag, 8);
    chk("b_cntI_64", longint'(cIb), 8);
    chk("b_cntQ_64", longint'(cQb), 0);
    chk("c_cntI_sat", longint'(cIc), 7);

    // Both branches, counter saturation.
    do_reset();
    repeat (40) tick(1, 1, 1, 2'b11);
    tick(0, 0, 1, 2'b11);
    @(posedge clk); #2;
    chk("c_cntI_40", longint'(cIc), 7);
    chk("c_cntQ_40", longint'(cQc), 7);
    chk("b_cntI_40", longint'(cIb), 5);
    chk("b_cntQ_40", longint'(cQb), 5);

    // Randomised traffic with occasional enable/select changes.
    begin
      bit ien = 1;
      logic [1:0] sel = 2'b11;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 31) == 0) ien = !ien;
        if ($urandom_range(0, 63) == 0) sel = 2'($urandom_range(0, 3));
        tick($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, ien, sel);
      end
    end

    // Asynchronous reset between edges.
    repeat (10) tick(1, 1, 1, 2'b11);
    @(negedge clk); #2;
    i_reset = 1'b0;
    #1;
    chk("async_bitI", longint'(bI[2]), 0);
    chk("async_bitQ", longint'(bQ[2]), 0);
    chk("async_valid", longint'(vld[2]), 0);
    chk("async_flag", longint'(flg[2]), 0);
    chk("async_cntI", longint'(cIc), 0);
    chk("async_cntQ", longint'(cQb), 0);
    i_en_tx = 0; i_en_rate1 = 0; i_err_inj_en = 0; i_err_sel = 2'b00;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    check_seed();
    repeat (5) tick(0, 0, 0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_prbs_qpsk_source.md
Name: tx_prbs_qpsk_source

Overview:
- Transmit-side bit source for the QPSK BER link. Two independent PRBS9 generators (I and Q) advance once per rate-1 strobe and drive registered I/Q bits into the mapper/upsampler.
- Their sequences match, bit for bit, the receiver-side PRBS9 checkers that use the same seeds.
- Optional periodic bit-error injection per branch, with an injected-error counter, lets the receive BER counters be checked against a known error rate.

Parameters:
- PRBS_SEED_I, 9'h1AA, reset state of I LFSR (must be non-zero).
- PRBS_SEED_Q, 9'h1FE, reset state of Q LFSR (must be non-zero).
- ERR_PERIOD, 1024, number of advances per injection window; legal range 2..65535.
- ERR_CNT_W, 32, width of the injected-error counters.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_en_tx  in  1  transmitter global enable.
- i_en_rate1  in  1  one-cycle symbol-rate strobe.
- i_err_inj_en  in  1  error-injection enable.
- i_err_sel  in  2  bit0 selects I injection, bit1 selects Q injection.
- o_tx_bit_I  out  1  registered I data bit.
- o_tx_bit_Q  out  1  registered Q data bit.
- o_tx_valid  out  1  one-cycle pulse, high the cycle after each advance.
- o_inj_flag  out  1  high while the current output symbol carries an injected error.
- o_err_cnt_I  out  ERR_CNT_W  count of injected I errors, saturating.
- o_err_cnt_Q  out  ERR_CNT_W  count of injected Q errors, saturating.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - lfsr_I = PRBS_SEED_I, lfsr_Q = PRBS_SEED_Q, window counter = 0.
  - All outputs = 0: o_tx_bit_I, o_tx_bit_Q, o_tx_valid, o_inj_flag, o_err_cnt_I, o_err_cnt_Q.
  - Reset mid-operation aborts everything immediately. After release, the sequence restarts from the seed.
- Advance: adv = i_en_tx & i_en_rate1. With adv = 0, all state and the data outputs hold, and o_tx_valid = 0.
- LFSR, polynomial x^9+x^5+1, for each branch r:
  - fb = r[8]^r[4]; on adv, r <= {r[7:0], fb}.
  - Output bit on the same adv = r[8] (pre-shift value) XOR inj_branch.
  - The first 9 output bits after reset are the seed, MSB first. The period is 511 advances, then the state equals the seed again.
- Lockup guard: if r == 0 on an adv (only possible after an SEU), load r <= 9'h1FF instead of shifting. The output for that advance is 0.
- Latency:
  - Output bits and o_tx_valid are registered, valid the cycle after the adv cycle.
  - o_tx_valid = 1 exactly one cycle per adv. Back-to-back adv gives continuous valid.
- Window counter:
  - Active only while i_err_inj_en = 1. When i_err_inj_en = 0 it is held at 0 and no injection occurs.
  - On adv: if cnt == ERR_PERIOD-1 then cnt <= 0 and inj = 1 for this advance; otherwise cnt <= cnt+1.
  - Enabling injection mid-stream starts a fresh window, so the first injection happens on the ERR_PERIOD-th advance after enable.
- Injection:
  - inj_I = inj & i_err_sel[0]; inj_Q = inj & i_err_sel[1].
  - Injection inverts the output bit only; the LFSR state is never altered, so the receiver stays synchronised.
  - o_inj_flag is registered with the data and equals inj_I | inj_Q.
  - If i_err_sel = 2'b00 while enabled, the counter runs but nothing is flipped and o_inj_flag stays 0.
- Error counters: o_err_cnt_I increments by 1 on each inj_I; o_err_cnt_Q on each inj_Q. Each saturates at all-ones and does not wrap. Counters clear only on reset.
- Simultaneous events:
  - i_err_sel and i_err_inj_en are sampled on the adv cycle.
  - Dropping i_err_inj_en on the injection advance itself suppresses that injection and clears the counter.

Test Plan:
- Reset, then 9 advances with injection off -> I bits 1,1,0,1,0,1,0,1,0 (seed 0x1AA); Q bits 1,1,1,1,1,1,1,1,0 (seed 0x1FE).
- 511 advances, then compare the next 511 bits -> identical sequence; internal lfsr_I == 0x1AA at the period boundary.
- i_en_tx=1 with i_en_rate1 pulsing 1-of-4 cycles, and i_en_tx dropped for 10 strobes -> o_tx_valid only on the cycle after each adv; bits unchanged while disabled; no sequence skip.
- ERR_PERIOD=8, i_err_sel=2'b01, 64 advances -> I bits 8,16,...,64 inverted versus a golden PRBS9; Q clean; o_err_cnt_I=8, o_err_cnt_Q=0; o_inj_flag high on those 8 symbols.
- ERR_CNT_W=3, i_err_sel=2'b11, ERR_PERIOD=2, 40 advances -> both counters stick at 7; injection continues on every 2nd bit.
- Assert i_reset=0 asynchronously mid-stream between clock edges -> outputs go to 0 immediately; after release the first 9 bits equal the seed again.
